mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 45 ++++
 rtl/load_store_align.sv | 54 +++++
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, funct3 load/store
// codes, writeback-select encodings and the access-size / alignment helpers.
package mem_access_stage_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Any funct3 that is not a defined byte/half code falls back to the word form.
   function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
      size_e sz;
      sz = SZ_WORD;
      if (is_store) begin
         if (f3 == F3_SB)      sz = SZ_BYTE;
         else if (f3 == F3_SH) sz = SZ_HALF;
      end else begin
         if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
         else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr_lo);
      logic mis;
      case (sz)
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables and lane-replicated write data,
// and load lane selection with sign/zero extension.
module load_store_align
   import mem_access_stage_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_is_store,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   size_e       w_size;
   logic [31:0] w_lane;

   always_comb begin
      w_size  = access_size(i_funct3, i_is_store);
      o_be    = 4'b1111;
      o_wdata = i_store_data;
      if (i_is_store) begin
         case (w_size)
            SZ_BYTE: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
               o_be    = 4'b0011 << i_addr_lo;
               o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
               o_be    = 4'b1111;
               o_wdata = i_store_data;
            end
         endcase
      end
   end

   // Shift the addressed lane down to bit 0 before extension.
   always_comb begin
      w_lane = i_rdata >> {i_addr_lo, 3'b000};
      case (i_funct3)
         F3_LB:   o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
         F3_LH:   o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
         F3_LBU:  o_load_data = {24'h0, w_lane[7:0]};
         F3_LHU:  o_load_data = {16'h0, w_lane[15:0]};
         F3_LW:   o_load_data = i_rdata;
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory port, stalls on slow memory, flags
// misaligned accesses and registers the MEM/WB fields.
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        LoadM,
   input  logic        StoreM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] InstrM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        StallM,
   output logic        MisalignM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        o_dbg_state
);

   // Memory handshake: a request is outstanding while dmem_req=1; it completes in the
   // first cycle dmem_ready=1. dmem_ready is ignored when dmem_req=0. While StallM=1 the
   // upstream holds every *M input stable, and the request fields stay frozen in WAIT.

   state_e      r_state, w_next_state;
   logic [2:0]  w_funct3;
   logic        w_access, w_misalign, w_misalign_hit, w_bubble, w_unused;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load_data;
   logic        r_we, r_misalign;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;

   assign w_funct3       = InstrM[14:12];
   assign w_access       = LoadM | StoreM;
   assign w_misalign     = w_access & is_misaligned(access_size(w_funct3, StoreM), ALU_ResultM[1:0]);
   assign w_misalign_hit = (r_state == ST_IDLE) & w_misalign;
   assign w_bubble       = StallM | w_misalign_hit;
   assign w_unused       = ^{InstrM[31:15], InstrM[11:0]};
   assign MisalignM      = r_misalign;

   load_store_align u_align (
      .i_funct3     (w_funct3),
      .i_addr_lo    (ALU_ResultM[1:0]),
      .i_is_store   (StoreM),
      .i_store_data (WriteDataM),
      .i_rdata      (dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_access && !w_misalign && !dmem_ready) w_next_state = ST_WAIT;
         ST_WAIT: if (dmem_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = {ALU_ResultM[31:2], 2'b00};
      dmem_wdata  = w_wdata;
      dmem_be     = w_be;
      o_dbg_state = r_state;
      case (r_state)
         ST_IDLE: begin
            dmem_req = w_access & ~w_misalign;
            dmem_we  = StoreM & dmem_req;
         end
         ST_WAIT: begin
            dmem_req   = 1'b1;
            dmem_we    = r_we;
            dmem_addr  = r_addr;
            dmem_wdata = r_wdata;
            dmem_be    = r_be;
         end
         default: ;
      endcase
      StallM = dmem_req & ~dmem_ready;
   end

   // Snapshot of the request taken in IDLE, replayed while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_be    <= 4'h0;
      end else if (r_state == ST_IDLE) begin
         r_we    <= StoreM;
         r_addr  <= {ALU_ResultM[31:2], 2'b00};
         r_wdata <= w_wdata;
         r_be    <= w_be;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misalign  <= 1'b0;
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 2'b00;
         RD_W        <= 5'd0;
         PCPlus4W    <= 32'h0;
         ALU_ResultW <= 32'h0;
         ReadDataW   <= 32'h0;
      end else begin
         r_misalign <= w_misalign_hit;
         if (w_bubble) begin
            RegWriteW <= 1'b0;
         end else begin
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (LoadM && !StoreM) ? w_load_data : 32'h0;
         end
      end
   end

endmodule
